// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit producing HI/LO for MFHI/MFLO.
// Radix-2 Booth multiply and restoring magnitude divide, one bit per cycle over 32 cycles.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [31:0] m_q, m_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic        accept_mult;
  logic        accept_div;
  logic        div_by_zero;
  logic        last_iter;
  logic [65:0] mstep;
  logic [64:0] dstep;

  // The accumulator carries one guard bit above the 32-bit HI word so that
  // subtracting a multiplicand of -2^31 cannot overflow.
  function automatic logic [65:0] booth_step(
    input logic signed [32:0] acc,
    input logic        [31:0] q,
    input logic               qm1,
    input logic        [31:0] m
  );
    logic signed [32:0] mx;
    logic signed [32:0] sum;
    mx = $signed({m[31], m});
    case ({q[0], qm1})
      2'b01:   sum = acc + mx;
      2'b10:   sum = acc - mx;
      default: sum = acc;
    endcase
    return {sum[32], sum, q};
  endfunction

  function automatic logic [64:0] div_step(
    input logic [32:0] rem,
    input logic [31:0] dvd,
    input logic [31:0] dsr
  );
    logic [32:0] rem_sh;
    logic [32:0] trial;
    rem_sh = {rem[31:0], dvd[31]};
    trial  = rem_sh - {1'b0, dsr};
    if (!trial[32]) begin
      return {trial, dvd[30:0], 1'b1};
    end
    return {rem_sh, dvd[30:0], 1'b0};
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  always_comb begin
    accept_mult = (state_q == S_IDLE) && mult_start;
    accept_div  = (state_q == S_IDLE) && !mult_start && div_start && (b != 32'd0);
    div_by_zero = (state_q == S_IDLE) && !mult_start && div_start && (b == 32'd0);
    last_iter   = (cnt_q == 5'd31);
    mstep       = booth_step(acc_q, q_q, qm1_q, m_q);
    dstep       = div_step(acc_q, q_q, m_q);
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_mult) begin
          state_d = S_MULT;
        end else if (accept_div) begin
          state_d = S_DIV;
        end
      end
      S_MULT:  if (last_iter) state_d = S_IDLE;
      S_DIV:   if (last_iter) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    q_d    = q_q;
    qm1_d  = qm1_q;
    m_d    = m_q;
    negq_d = negq_q;
    negr_d = negr_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    dz_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_mult) begin
          cnt_d = 5'd0;
          acc_d = 33'd0;
          q_d   = a;
          qm1_d = 1'b0;
          m_d   = b;
        end else if (accept_div) begin
          cnt_d  = 5'd0;
          acc_d  = 33'd0;
          q_d    = mag32(a);
          m_d    = mag32(b);
          negq_d = a[31] ^ b[31];
          negr_d = a[31];
        end else if (div_by_zero) begin
          dz_d = 1'b1;
        end
      end
      S_MULT: begin
        cnt_d = cnt_q + 5'd1;
        acc_d = mstep[65:33];
        q_d   = mstep[32:1];
        qm1_d = mstep[0];
        if (last_iter) begin
          hi_d   = mstep[64:33];
          lo_d   = mstep[32:1];
          done_d = 1'b1;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 5'd1;
        acc_d = dstep[64:32];
        q_d   = dstep[31:0];
        if (last_iter) begin
          hi_d   = apply_sign(dstep[63:32], negr_q);
          lo_d   = apply_sign(dstep[31:0], negq_q);
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= 5'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  // Working datapath registers are always loaded on accept before use.
  always_ff @(posedge clock) begin
    acc_q  <= acc_d;
    q_q    <= q_d;
    qm1_q  <= qm1_d;
    m_q    <= m_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clock      (clock),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          is_div;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input bit is_div, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, p, qt, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!is_div) begin
      p  = sx * sy;
      eh = p[63:32];
      el = p[31:0];
    end else begin
      qt = sx / sy;
      r  = sx % sy;
      eh = r[31:0];
      el = qt[31:0];
    end
  endfunction

  // Issue one operation from IDLE and wait for its done pulse.
  task automatic run_op(input bit is_div, input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] rh, output logic [31:0] rl, output int lat);
    mult_start = !is_div;
    div_start  = is_div;
    a = va;
    b = vb;
    tick();
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("done_low_after_accept", {31'd0, done}, 32'd0);
    mult_start = 1'b0;
    div_start  = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    rh = hi;
    rl = lo;
    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rh, rl, eh, el, ra, rb;
    int lat, ndone, done_at;
    logic [31:0] dh, dl;

    vecs[0] = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{1'b1, 32'd100,       32'd7,        32'd2,        32'd14};
    vecs[5] = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000};

    reset = 1'b1;
    mult_start = 1'b0;
    div_start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) tick();
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_div_zero", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].is_div, vecs[i].va, vecs[i].vb, rh, rl, lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd32);
      chk($sformatf("vec%0d_hi", i), rh, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), rl, vecs[i].exp_lo);
    end

    // Divide by zero right after the overflow divide: pulse only, HI/LO kept.
    div_start = 1'b1;
    a = 32'd5;
    b = 32'd0;
    tick();
    div_start = 1'b0;
    chk("dz_pulse", {31'd0, div_zero}, 32'd1);
    chk("dz_busy", {31'd0, busy}, 32'd0);
    chk("dz_done", {31'd0, done}, 32'd0);
    chk("dz_hi_kept", hi, 32'd0);
    chk("dz_lo_kept", lo, 32'h80000000);
    tick();
    chk("dz_pulse_end", {31'd0, div_zero}, 32'd0);
    chk("dz_busy_end", {31'd0, busy}, 32'd0);

    // Both starts together: multiply wins; a divide request mid-operation is ignored.
    mult_start = 1'b1;
    div_start = 1'b1;
    a = 32'd6;
    b = 32'd3;
    tick();
    mult_start = 1'b0;
    div_start = 1'b0;
    chk("both_busy", {31'd0, busy}, 32'd1);
    ndone = 0;
    done_at = 0;
    dh = 32'd0;
    dl = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      div_start = (i == 5);
      b = (i == 5) ? 32'd1 : 32'd3;
      tick();
      if (done === 1'b1) begin
        ndone++;
        done_at = i;
        dh = hi;
        dl = lo;
      end
    end
    div_start = 1'b0;
    chk("both_done_count", ndone, 32'd1);
    chk("both_done_at", done_at, 32'd32);
    chk("both_hi", dh, 32'd0);
    chk("both_lo", dl, 32'd18);
    chk("both_idle_after", {31'd0, busy}, 32'd0);

    // Reset during iteration 10 of a multiply.
    mult_start = 1'b1;
    a = 32'h00012345;
    b = 32'h00000777;
    tick();
    mult_start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    run_op(1'b0, 32'd3, 32'd4, rh, rl, lat);
    chk("postrst_latency", lat, 32'd32);
    chk("postrst_hi", rh, 32'd0);
    chk("postrst_lo", rl, 32'd12);

    // Randomised operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      bit is_div;
      is_div = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: ra = 32'h80000000;
        1: ra = $urandom_range(0, 20) - 10;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = 32'hFFFFFFFF;
        1: rb = $urandom_range(0, 20) - 10;
        default: rb = $urandom;
      endcase
      if (is_div && rb == 32'd0) rb = 32'd3;
      model(is_div, ra, rb, eh, el);
      run_op(is_div, ra, rb, rh, rl, lat);
      chk($sformatf("rnd%0d_latency", i), lat, 32'd32);
      chk($sformatf("rnd%0d_hi_%s_%h_%h", i, is_div ? "div" : "mul", ra, rb), rh, eh);
      chk($sformatf("rnd%0d_lo_%s_%h_%h", i, is_div ? "div" : "mul", ra, rb), rl, el);
    end

    tick();
    chk("final_done_low", {31'd0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
